ahb_slave_port_sched: RTL and testbench

// - Per-slave-port scheduler between AHB masters and the matrix arbiter; one per slave port.
// - Raises arbiter requests and acknowledges grants only when the address slot is free.
// - Holds ownership across fixed bursts, INCR bursts and HMASTLOCK sequences.
// - Tracks the address-phase and data-phase owners; returns per-master HREADY.

---
 rtl/ahb_slave_port_sched_if.sv | 56 +++++
 rtl/ahb_slave_port_sched.sv | 185 ++++++++++++++++++
 tb/tb_ahb_slave_port_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_port_sched_if.sv
// ---------------------------------------------------------------------------
// ahb_slave_port_sched_if
// Bus bundle between the AHB masters / matrix arbiter and one slave-port
// scheduler.
//
// Handshake: an address phase is taken when ADDR_VALID and S_HREADY are both
// high in the same cycle. Its data phase occupies the next cycle(s) until
// S_HREADY is sampled high again. ARB_GRANT_ACK is asserted in the cycle the
// scheduler takes the granted master's address.
//
// Signals (MASTERS = number of masters sharing the slave port):
//   M_REQ, M_NONSEQ, M_HMASTLOCK  [MASTERS]    per-master address-phase info
//   M_HBURST                      [3*MASTERS]  HBURST of master m at [3m+2:3m]
//   S_HREADY                                   slave HREADYOUT
//   ARB_REQ, ARB_REQ_ACK          [MASTERS]    arbiter request / request ack
//   ARB_GRANT, ARB_GRANT_ACK      [MASTERS]    one-hot grant / grant accepted
//   ARB_PRIORITY_LOCK                          freeze arbiter pointers
//   ADDR_SEL, ADDR_VALID                       address-phase owner / valid
//   DATA_SEL, DATA_VALID                       data-phase owner / valid
//   M_HREADY                      [MASTERS]    HREADY returned to each master
// ---------------------------------------------------------------------------
interface ahb_slave_port_sched_if #(
    parameter int MASTERS = 8
);
    logic [MASTERS-1:0]   M_REQ;
    logic [MASTERS-1:0]   M_NONSEQ;
    logic [3*MASTERS-1:0] M_HBURST;
    logic [MASTERS-1:0]   M_HMASTLOCK;
    logic                 S_HREADY;
    logic [MASTERS-1:0]   ARB_REQ;
    logic [MASTERS-1:0]   ARB_REQ_ACK;
    logic [MASTERS-1:0]   ARB_GRANT;
    logic [MASTERS-1:0]   ARB_GRANT_ACK;
    logic                 ARB_PRIORITY_LOCK;
    logic [MASTERS-1:0]   ADDR_SEL;
    logic                 ADDR_VALID;
    logic [MASTERS-1:0]   DATA_SEL;
    logic                 DATA_VALID;
    logic [MASTERS-1:0]   M_HREADY;

    // Scheduler side.
    modport slave (
        input  M_REQ, M_NONSEQ, M_HBURST, M_HMASTLOCK, S_HREADY,
        input  ARB_REQ_ACK, ARB_GRANT,
        output ARB_REQ, ARB_GRANT_ACK, ARB_PRIORITY_LOCK,
        output ADDR_SEL, ADDR_VALID, DATA_SEL, DATA_VALID, M_HREADY
    );

    // Masters / arbiter / slave side.
    modport master (
        output M_REQ, M_NONSEQ, M_HBURST, M_HMASTLOCK, S_HREADY,
        output ARB_REQ_ACK, ARB_GRANT,
        input  ARB_REQ, ARB_GRANT_ACK, ARB_PRIORITY_LOCK,
        input  ADDR_SEL, ADDR_VALID, DATA_SEL, DATA_VALID, M_HREADY
    );
endinterface

// File: rtl/ahb_slave_port_sched.sv
// ---------------------------------------------------------------------------
// ahb_slave_port_sched
// Per-slave-port scheduler between AHB masters and the matrix arbiter.
// Requests arbitration for every master addressing this slave, accepts a
// grant only when the address slot is free, keeps ownership across fixed
// bursts, INCR bursts and HMASTLOCK sequences, and tracks the address- and
// data-phase owners to steer the muxes and return per-master HREADY.
//
// Ports:
//   HCLK         clock
//   HRESET       synchronous active-high reset
//   bus          ahb_slave_port_sched_if.slave (all bus/arbiter signals)
//   dbg_state_o  current FSM state (0 = ARB, 1 = BURST, 2 = LOCK)
// ---------------------------------------------------------------------------
module ahb_slave_port_sched #(
    parameter int MASTERS     = 8,
    parameter int MASTERS_BIT = $clog2(MASTERS)
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    ahb_slave_port_sched_if.slave      bus,
    output logic [1:0]                 dbg_state_o
);

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_BURST = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [2:0] HB_INCR = 3'b001;

    state_t                 state_q, state_d;
    logic [MASTERS_BIT-1:0] owner_q, owner_d;
    logic [4:0]             beats_q, beats_d;
    logic                   incr_q, incr_d;
    logic                   lock_q, lock_d;
    logic [MASTERS-1:0]     dsel_q, dsel_d;
    logic                   dvalid_q, dvalid_d;

    logic [MASTERS_BIT-1:0] grant_idx;
    logic [MASTERS-1:0]     owner_oh;
    logic [MASTERS-1:0]     addr_sel;
    logic                   addr_valid;
    logic [MASTERS-1:0]     grant_ack;
    logic                   accept;
    logic [MASTERS-1:0]     m_hready;
    logic [2:0]             hb_g;
    logic                   own_req;
    logic                   own_nonseq;
    logic                   own_lock;

    // The request ack is informational only; nothing is steered by it.
    logic unused_req_ack;
    assign unused_req_ack = ^bus.ARB_REQ_ACK;

    // Remaining beats after the first accepted beat of a fixed burst.
    function automatic logic [4:0] burst_rem(input logic [2:0] hb);
        case (hb)
            3'b010, 3'b011: burst_rem = 5'd3;
            3'b100, 3'b101: burst_rem = 5'd7;
            3'b110, 3'b111: burst_rem = 5'd15;
            default:        burst_rem = 5'd0;
        endcase
    endfunction

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (bus.ARB_GRANT[i]) grant_idx = MASTERS_BIT'(i);
        end
        hb_g       = bus.M_HBURST[3*grant_idx +: 3];
        owner_oh   = MASTERS'(1) << owner_q;
        own_req    = bus.M_REQ[owner_q];
        own_nonseq = bus.M_NONSEQ[owner_q];
        own_lock   = bus.M_HMASTLOCK[owner_q];

        addr_sel   = '0;
        addr_valid = 1'b0;
        grant_ack  = '0;
        case (state_q)
            ST_ARB: begin
                addr_sel   = bus.ARB_GRANT;
                addr_valid = |bus.ARB_GRANT;
                grant_ack  = bus.ARB_GRANT & {MASTERS{bus.S_HREADY}};
            end
            ST_BURST: begin
                // A NONSEQ from the owner ends the burst and must be re-arbitrated.
                addr_sel   = owner_oh;
                addr_valid = own_req & ~own_nonseq;
            end
            ST_LOCK: begin
                addr_sel   = owner_oh;
                addr_valid = own_req;
            end
            default: ;
        endcase
        accept = addr_valid & bus.S_HREADY;

        // Data-phase owner sees the slave's HREADY; a requester not being
        // taken this cycle is stalled; everybody else sees ready.
        for (int m = 0; m < MASTERS; m++) begin
            if (dvalid_q && dsel_q[m])
                m_hready[m] = bus.S_HREADY;
            else if (bus.M_REQ[m] && !(addr_sel[m] && accept))
                m_hready[m] = 1'b0;
            else
                m_hready[m] = 1'b1;
        end
    end

    // Next state: everything holds while the slave stalls.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        beats_d  = beats_q;
        incr_d   = incr_q;
        lock_d   = lock_q;
        dsel_d   = dsel_q;
        dvalid_d = dvalid_q;
        if (bus.S_HREADY) begin
            dsel_d   = addr_sel;
            dvalid_d = addr_valid;
            case (state_q)
                ST_ARB: begin
                    if (accept) begin
                        owner_d = grant_idx;
                        beats_d = burst_rem(hb_g);
                        incr_d  = (hb_g == HB_INCR);
                        if (bus.M_HMASTLOCK[grant_idx])
                            state_d = ST_LOCK;
                        else if (hb_g == HB_INCR || burst_rem(hb_g) != 5'd0)
                            state_d = ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (own_req && own_nonseq) begin
                        state_d = ST_ARB;
                    end else if (incr_q) begin
                        if (!own_req) state_d = ST_ARB;
                    end else if (accept) begin
                        beats_d = beats_q - 5'd1;
                        if (beats_q == 5'd1) state_d = ST_ARB;
                    end
                end
                ST_LOCK: begin
                    if (!own_lock) state_d = ST_ARB;
                end
                default: state_d = ST_ARB;
            endcase
            lock_d = (state_d == ST_LOCK);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ST_ARB;
            owner_q  <= '0;
            beats_q  <= '0;
            incr_q   <= 1'b0;
            lock_q   <= 1'b0;
            dsel_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            beats_q  <= beats_d;
            incr_q   <= incr_d;
            lock_q   <= lock_d;
            dsel_q   <= dsel_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign bus.ARB_REQ           = bus.M_REQ;
    assign bus.ARB_GRANT_ACK     = grant_ack;
    assign bus.ARB_PRIORITY_LOCK = lock_q;
    assign bus.ADDR_SEL          = addr_sel;
    assign bus.ADDR_VALID        = addr_valid;
    assign bus.DATA_SEL          = dsel_q;
    assign bus.DATA_VALID        = dvalid_q;
    assign bus.M_HREADY          = m_hready;
    assign dbg_state_o           = state_q;

endmodule

// File: tb/tb_ahb_slave_port_sched.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_port_sched
// Directed vectors for the slave-port scheduler. Each record is one clock
// cycle: inputs are applied just after the rising edge and the outputs are
// compared at the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_ahb_slave_port_sched;

    localparam int M = 8;

    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR   = 3'b001;
    localparam logic [2:0] INCR4  = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101;
    localparam logic [2:0] INCR16 = 3'b111;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    ahb_slave_port_sched_if #(.MASTERS(M)) bus ();

    ahb_slave_port_sched #(.MASTERS(M)) dut (
        .HCLK        (clk),
        .HRESET      (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    // Arbiter model: the request ack mirrors request & grant-accept.
    assign bus.ARB_REQ_ACK = bus.ARB_REQ & bus.ARB_GRANT_ACK;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [7:0]  nonseq;
        logic [23:0] hburst;
        logic [7:0]  lock;
        logic [7:0]  grant;
        logic        hready;
        logic        chk;
        logic [7:0]  e_ack;
        logic [7:0]  e_asel;
        logic        e_av;
        logic [7:0]  e_dsel;
        logic        e_dv;
        logic [7:0]  e_mhr;
        logic        e_plock;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [23:0] hb(input int m, input logic [2:0] c);
        hb = 24'(c) << (3 * m);
    endfunction

    function automatic vec_t mk(
        input logic rst_v, input logic [7:0] req, input logic [7:0] ns,
        input logic [23:0] hbv, input logic [7:0] lk, input logic [7:0] gr,
        input logic hr, input logic chk,
        input logic [7:0] ack, input logic [7:0] asel, input logic av,
        input logic [7:0] dsel, input logic dv, input logic [7:0] mhr,
        input logic pl, input logic [1:0] st);
        vec_t v;
        v.rst = rst_v; v.req = req; v.nonseq = ns; v.hburst = hbv;
        v.lock = lk; v.grant = gr; v.hready = hr; v.chk = chk;
        v.e_ack = ack; v.e_asel = asel; v.e_av = av; v.e_dsel = dsel;
        v.e_dv = dv; v.e_mhr = mhr; v.e_plock = pl; v.e_state = st;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic cmp(input string name, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %02h expected %02h", name, idx, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v, input int idx);
        rst                = v.rst;
        bus.M_REQ          = v.req;
        bus.M_NONSEQ       = v.nonseq;
        bus.M_HBURST       = v.hburst;
        bus.M_HMASTLOCK    = v.lock;
        bus.ARB_GRANT      = v.grant;
        bus.S_HREADY       = v.hready;
        @(negedge clk);
        if (v.chk) begin
            cmp("arb_req",    idx, bus.ARB_REQ,                 v.req);
            cmp("grant_ack",  idx, bus.ARB_GRANT_ACK,           v.e_ack);
            cmp("addr_sel",   idx, bus.ADDR_SEL,                v.e_asel);
            cmp("addr_valid", idx, 8'(bus.ADDR_VALID),          8'(v.e_av));
            cmp("data_sel",   idx, bus.DATA_SEL,                v.e_dsel);
            cmp("data_valid", idx, 8'(bus.DATA_VALID),          8'(v.e_dv));
            cmp("m_hready",   idx, bus.M_HREADY,                v.e_mhr);
            cmp("prio_lock",  idx, 8'(bus.ARB_PRIORITY_LOCK),   8'(v.e_plock));
            cmp("state",      idx, 8'(dbg_state),               8'(v.e_state));
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst             = 1'b1;
        bus.M_REQ       = '0;
        bus.M_NONSEQ    = '0;
        bus.M_HBURST    = '0;
        bus.M_HMASTLOCK = '0;
        bus.ARB_GRANT   = '0;
        bus.S_HREADY    = 1'b0;

        //             rst req    ns     hburst          lock   grant  hr  chk ack    asel   av  dsel   dv  mhr    pl  st
        // reset, then reset values
        tbl.push_back(mk(1, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 0,  0,  8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 0,  0,  8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0));
        // M0 SINGLE: same-cycle ack, data phase next cycle
        tbl.push_back(mk(0, 8'h01, 8'h01, hb(0, SINGLE), 8'h00, 8'h01, 1,  1,  8'h01, 8'h01, 1, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h01, 1, 8'hFF, 0, 0));
        // M2 INCR4 while M1 waits
        tbl.push_back(mk(0, 8'h06, 8'h06, hb(2, INCR4),  8'h00, 8'h04, 1,  1,  8'h04, 8'h04, 1, 8'h00, 0, 8'hFD, 0, 0));
        tbl.push_back(mk(0, 8'h06, 8'h02, hb(2, INCR4),  8'h00, 8'h02, 1,  1,  8'h00, 8'h04, 1, 8'h04, 1, 8'hFD, 0, 1));
        tbl.push_back(mk(0, 8'h06, 8'h02, hb(2, INCR4),  8'h00, 8'h02, 1,  1,  8'h00, 8'h04, 1, 8'h04, 1, 8'hFD, 0, 1));
        tbl.push_back(mk(0, 8'h06, 8'h02, hb(2, INCR4),  8'h00, 8'h02, 1,  1,  8'h00, 8'h04, 1, 8'h04, 1, 8'hFD, 0, 1));
        tbl.push_back(mk(0, 8'h02, 8'h02, 24'h0,         8'h00, 8'h02, 1,  1,  8'h02, 8'h02, 1, 8'h04, 1, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h02, 1, 8'hFF, 0, 0));
        // grant in ARB while the slave stalls: no ack
        tbl.push_back(mk(0, 8'h01, 8'h01, 24'h0,         8'h00, 8'h01, 0,  1,  8'h00, 8'h01, 1, 8'h00, 0, 8'hFE, 0, 0));
        tbl.push_back(mk(0, 8'h01, 8'h01, 24'h0,         8'h00, 8'h01, 1,  1,  8'h01, 8'h01, 1, 8'h00, 0, 8'hFF, 0, 0));
        // M3 INCR4 with a 3-cycle stall on beat 2
        tbl.push_back(mk(0, 8'h08, 8'h08, hb(3, INCR4),  8'h00, 8'h08, 1,  1,  8'h08, 8'h08, 1, 8'h01, 1, 8'hFF, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 8'h08, 8'h00, hb(3, INCR4), 8'h00, 8'h00, 0, 1, 8'h00, 8'h08, 1, 8'h08, 1, 8'hF7, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 8'h08, 8'h00, hb(3, INCR4), 8'h00, 8'h00, 1, 1, 8'h00, 8'h08, 1, 8'h08, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h08, 1, 8'hFF, 0, 0));
        // M1 locked sequence of 3 transfers while M0 requests
        tbl.push_back(mk(0, 8'h03, 8'h03, 24'h0,         8'h02, 8'h02, 1,  1,  8'h02, 8'h02, 1, 8'h00, 0, 8'hFE, 0, 0));
        tbl.push_back(mk(0, 8'h03, 8'h03, 24'h0,         8'h02, 8'h01, 1,  1,  8'h00, 8'h02, 1, 8'h02, 1, 8'hFE, 1, 2));
        tbl.push_back(mk(0, 8'h03, 8'h03, 24'h0,         8'h02, 8'h01, 1,  1,  8'h00, 8'h02, 1, 8'h02, 1, 8'hFE, 1, 2));
        tbl.push_back(mk(0, 8'h01, 8'h01, 24'h0,         8'h00, 8'h01, 1,  1,  8'h00, 8'h02, 0, 8'h02, 1, 8'hFE, 1, 2));
        tbl.push_back(mk(0, 8'h01, 8'h01, 24'h0,         8'h00, 8'h01, 1,  1,  8'h01, 8'h01, 1, 8'h02, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h01, 1, 8'hFF, 0, 0));
        // M4 INCR8 terminated by a NONSEQ on beat 3, re-arbitrated
        tbl.push_back(mk(0, 8'h10, 8'h10, hb(4, INCR8),  8'h00, 8'h10, 1,  1,  8'h10, 8'h10, 1, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h10, 8'h00, hb(4, INCR8),  8'h00, 8'h00, 1,  1,  8'h00, 8'h10, 1, 8'h10, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h10, 8'h10, hb(4, SINGLE), 8'h00, 8'h00, 1,  1,  8'h00, 8'h10, 0, 8'h10, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h10, 8'h10, hb(4, SINGLE), 8'h00, 8'h10, 1,  1,  8'h10, 8'h10, 1, 8'h10, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h10, 1, 8'hFF, 0, 0));
        // M5 INCR: owner dropping its request ends the burst
        tbl.push_back(mk(0, 8'h20, 8'h20, hb(5, INCR),   8'h00, 8'h20, 1,  1,  8'h20, 8'h20, 1, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h20, 8'h00, hb(5, INCR),   8'h00, 8'h00, 1,  1,  8'h00, 8'h20, 1, 8'h20, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, hb(5, INCR),   8'h00, 8'h00, 1,  1,  8'h00, 8'h20, 0, 8'h20, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h20, 0, 8'hFF, 0, 0));
        // M6 INCR4 with a BUSY cycle and a stalled last beat
        tbl.push_back(mk(0, 8'h40, 8'h40, hb(6, INCR4),  8'h00, 8'h40, 1,  1,  8'h40, 8'h40, 1, 8'h00, 0, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 8'h00, 8'h00, hb(6, INCR4),  8'h00, 8'h00, 1,  1,  8'h00, 8'h40, 0, 8'h40, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h40, 8'h00, hb(6, INCR4),  8'h00, 8'h00, 1,  1,  8'h00, 8'h40, 1, 8'h40, 0, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h40, 8'h00, hb(6, INCR4),  8'h00, 8'h00, 1,  1,  8'h00, 8'h40, 1, 8'h40, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h40, 8'h00, hb(6, INCR4),  8'h00, 8'h00, 0,  1,  8'h00, 8'h40, 1, 8'h40, 1, 8'hBF, 0, 1));
        tbl.push_back(mk(0, 8'h40, 8'h00, hb(6, INCR4),  8'h00, 8'h00, 1,  1,  8'h00, 8'h40, 1, 8'h40, 1, 8'hFF, 0, 1));
        tbl.push_back(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1,  1,  8'h00, 8'h00, 0, 8'h40, 1, 8'hFF, 0, 0));

        @(posedge clk);
        #1;
        foreach (tbl[i]) run_vec(tbl[i], i);

        // Reset taken in the middle of an M7 INCR16.
        run_vec(mk(0, 8'h80, 8'h80, hb(7, INCR16), 8'h00, 8'h80, 1, 1, 8'h80, 8'h80, 1, 8'h00, 0, 8'hFF, 0, 0), 100);
        run_vec(mk(0, 8'h80, 8'h00, hb(7, INCR16), 8'h00, 8'h00, 1, 1, 8'h00, 8'h80, 1, 8'h80, 1, 8'hFF, 0, 1), 101);
        run_vec(mk(1, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0), 102);
        run_vec(mk(0, 8'h00, 8'h00, 24'h0,         8'h00, 8'h00, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0), 103);

        // Reset taken in the middle of an M6 locked sequence; lock still held.
        run_vec(mk(0, 8'h40, 8'h40, 24'h0,         8'h40, 8'h40, 1, 1, 8'h40, 8'h40, 1, 8'h00, 0, 8'hFF, 0, 0), 104);
        run_vec(mk(0, 8'h40, 8'h00, 24'h0,         8'h40, 8'h00, 1, 1, 8'h00, 8'h40, 1, 8'h40, 1, 8'hFF, 1, 2), 105);
        run_vec(mk(1, 8'h00, 8'h00, 24'h0,         8'h40, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0), 106);
        run_vec(mk(0, 8'h00, 8'h00, 24'h0,         8'h40, 8'h00, 1, 1, 8'h00, 8'h00, 0, 8'h00, 0, 8'hFF, 0, 0), 107);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
